wakeup_mw: RTL and testbench
============================

Name: wakeup_mw

Overview:
- Multi-width successor to the single-dispatch wakeup matrix.
- Reservation-station bookkeeping with DISP_WIDTH dispatch lanes, ISSUE_WIDTH grant ports and RETIRE_WIDTH retire ports.
- Adds pipeline flush and a registered occupancy counter.
- Sits between rename/dispatch and the select arbiters; per-entry readiness is cleared by the execute-side ready_mask.

Parameters:
- RS_ENTRIES, 16, reservation-station depth (power of two, >=4).
- NUM_FUS, 2, functional-unit pipes; the dependency vector is RS_ENTRIES*NUM_FUS bits, one per (FU, entry) producer.
- DISP_WIDTH, 2, dispatch lanes per cycle (1..4).
- ISSUE_WIDTH, 2, grant ports per cycle.
- RETIRE_WIDTH, 2, retire ports per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  DISP_WIDTH  per-lane dispatch request.
- disp_dep_mask  in  DISP_WIDTH x (RS_ENTRIES*NUM_FUS)  producer dependencies per lane.
- disp_ready  out  DISP_WIDTH  lane k has an allocated free entry.
- disp_entry  out  DISP_WIDTH x log2(RS_ENTRIES)  entry allocated to lane k.
- full  out  1  no free entry.
- occupancy  out  log2(RS_ENTRIES)+1  registered count of valid entries.
- reqs  out  RS_ENTRIES  request vector to select.
- grant_valid  in  ISSUE_WIDTH  per-port grant.
- grant_entry  in  ISSUE_WIDTH x log2(RS_ENTRIES)  granted entry.
- ready_mask  in  RS_ENTRIES*NUM_FUS  producers broadcast ready this cycle.
- retire_valid  in  RETIRE_WIDTH  per-port retire.
- retire_entry  in  RETIRE_WIDTH x log2(RS_ENTRIES)  entry to free.
- flush  in  1  synchronous squash of all entries.

Behaviour:
- Reset (async, rst=1): entry_valid, entry_granted, all dependency rows and occupancy = 0. Outputs: reqs=0, full=0, disp_ready=all ones (when RS_ENTRIES>=DISP_WIDTH), disp_entry[k]=k.
- Free finder (combinational, from registered state only): disp_entry[k] = k-th lowest-index invalid entry. disp_ready[k]=1 iff at least k+1 entries are free. full = (free count == 0).
- An entry freed by retire in cycle N is not offered until N+1.
- Dispatch on lane k occurs iff disp_valid[k] & disp_ready[k]; otherwise the lane is ignored. Lanes are independent, so a hole such as lane0 off, lane1 on is legal.
- On dispatch: row <= disp_dep_mask[k] & ~ready_mask; valid<=1; granted<=0.
- Every cycle, every non-dispatching row <= row & ~ready_mask.
- reqs[i] = valid[i] & ~granted[i] & (row[i]==0), from registered state. Wakeup-to-request latency is 1 cycle after the ready_mask cycle.
- Grant: sets granted[e] only if valid[e]; grants to invalid entries are ignored. Duplicate grants to the same entry are harmless.
- Retire: clears valid and granted. Retiring an invalid entry is a no-op and does not decrement occupancy.
- Retire and grant to the same entry in the same cycle: retire wins.
- Flush: clears all valid, granted and rows, and occupancy<=0. It has priority over same-cycle dispatch, grant and retire.
- occupancy_next = occupancy + (#dispatches) - (#distinct valid entries retired). Duplicate retire indices count once. The value never exceeds RS_ENTRIES and never underflows.
- Invariant: occupancy == popcount(entry_valid), checked by an SVA assertion.

Optional Feature:
- Macro WAKEUP_REPLAY_EN.
- When defined, adds two ports: replay_valid (in, ISSUE_WIDTH) and replay_entry (in, ISSUE_WIDTH x log2(RS_ENTRIES)).
- Replay clears granted[e] for a valid entry e, so the entry re-requests the next cycle with its dependency row unchanged.
- Priority: replay overrides a same-cycle grant to the same entry; retire and flush override replay.
- When undefined, the ports are absent and granted is cleared only by retire or flush.

Decomposition:
- Package wakeup_pkg holds:
  - default constants RS_ENTRIES_DFLT and NUM_FUS_DFLT;
  - a function popcount;
  - a typedef for an index-with-valid lane struct, shared by the grant, retire and replay ports.
- Sub-module rs_free_finder: multi-output priority encoder (parameters RS_ENTRIES, DISP_WIDTH) producing disp_entry, disp_ready and full.

Test Plan (RS_ENTRIES=8, NUM_FUS=2, widths=2):
- Reset then dispatch both lanes with dep=0 → entries 0,1 valid; reqs=8'b0000_0011 next cycle; occupancy=2.
- Fill 7 entries → disp_ready=2'b01, disp_entry[0]=7. Dispatch both lanes → only entry 7 written, full=1, occupancy=8.
- Dispatch entry 2 with dep bit 5 while ready_mask bit 5 is asserted the same cycle → reqs[2]=1 next cycle. With ready_mask bit 5 asserted one cycle later instead → reqs[2]=1 two cycles after dispatch.
- Grant entry 3 on both ports and retire entry 3 twice in one cycle → valid[3]=0 and occupancy decrements by exactly 1.
- Flush with occupancy=5 while dispatching on lane 0 → occupancy=0, reqs=0, full=0; the dispatch is dropped.
- With WAKEUP_REPLAY_EN: grant entry 4 (reqs[4] drops), then replay entry 4 → reqs[4]=1 again next cycle. Assert rst mid-sequence → all state is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wakeup_pkg.sv
// Shared constants, lane struct and popcount helper for the multi-width wakeup matrix.
// Index lanes are LANE_IDX_W wide, so designs up to 256 entries share one struct type.
package wakeup_pkg;

    localparam int RS_ENTRIES_DFLT = 16;
    localparam int NUM_FUS_DFLT    = 2;
    localparam int LANE_IDX_W      = 8;
    localparam int POP_W           = 256;

    typedef struct packed {
        logic                  vld;
        logic [LANE_IDX_W-1:0] idx;
    } lane_idx_t;

    function automatic logic [8:0] popcount(input logic [POP_W-1:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + 9'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rs_free_finder.sv
// Multi-output priority encoder: lane k receives the k-th lowest-index free entry.
// Works only from registered valid bits, so a just-retired entry shows up a cycle later.
module rs_free_finder
    import wakeup_pkg::*;
#(
    parameter int RS_ENTRIES = RS_ENTRIES_DFLT,
    parameter int DISP_WIDTH = 2,
    parameter int IDX_W      = $clog2(RS_ENTRIES)
) (
    input  logic [RS_ENTRIES-1:0]       i_valid,
    output logic [DISP_WIDTH*IDX_W-1:0] o_disp_entry,
    output logic [DISP_WIDTH-1:0]       o_disp_ready,
    output logic                        o_full
);

    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]            w_rank;
    logic [DISP_WIDTH*IDX_W-1:0] w_entry;
    logic [DISP_WIDTH-1:0]       w_ready;

    always_comb begin
        w_rank  = '0;
        w_entry = '0;
        w_ready = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!i_valid[i]) begin
                for (int k = 0; k < DISP_WIDTH; k++) begin
                    if (w_rank == CNT_W'(k)) begin
                        w_entry[k*IDX_W +: IDX_W] = IDX_W'(i);
                        w_ready[k]                = 1'b1;
                    end
                end
                w_rank = w_rank + 1'b1;
            end
        end
    end

    assign o_disp_entry = w_entry;
    assign o_disp_ready = w_ready;
    assign o_full       = &i_valid;

endmodule

// File: rtl/wakeup_mw.sv
// Multi-width reservation-station wakeup matrix with flush and registered occupancy.
// Optional WAKEUP_REPLAY_EN adds replay ports that clear an entry's granted bit.
module wakeup_mw
    import wakeup_pkg::*;
#(
    parameter int RS_ENTRIES   = RS_ENTRIES_DFLT,
    parameter int NUM_FUS      = NUM_FUS_DFLT,
    parameter int DISP_WIDTH   = 2,
    parameter int ISSUE_WIDTH  = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int IDX_W        = $clog2(RS_ENTRIES),
    parameter int DEP_W        = RS_ENTRIES * NUM_FUS,
    parameter int OCC_W        = IDX_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DISP_WIDTH-1:0]         i_disp_valid,
    input  logic [DISP_WIDTH*DEP_W-1:0]   i_disp_dep_mask,
    output logic [DISP_WIDTH-1:0]         o_disp_ready,
    output logic [DISP_WIDTH*IDX_W-1:0]   o_disp_entry,
    output logic                          o_full,
    output logic [OCC_W-1:0]              o_occupancy,
    output logic [RS_ENTRIES-1:0]         o_reqs,
    input  logic [ISSUE_WIDTH-1:0]        i_grant_valid,
    input  logic [ISSUE_WIDTH*IDX_W-1:0]  i_grant_entry,
    input  logic [DEP_W-1:0]              i_ready_mask,
    input  logic [RETIRE_WIDTH-1:0]       i_retire_valid,
    input  logic [RETIRE_WIDTH*IDX_W-1:0] i_retire_entry,
`ifdef WAKEUP_REPLAY_EN
    input  logic [ISSUE_WIDTH-1:0]        i_replay_valid,
    input  logic [ISSUE_WIDTH*IDX_W-1:0]  i_replay_entry,
`endif
    input  logic                          i_flush
);

    logic [RS_ENTRIES-1:0] r_valid;
    logic [RS_ENTRIES-1:0] r_granted;
    logic [DEP_W-1:0]      r_row [RS_ENTRIES];
    logic [OCC_W-1:0]      r_occupancy;

    logic [RS_ENTRIES-1:0] w_valid_nxt;
    logic [RS_ENTRIES-1:0] w_granted_nxt;
    logic [DEP_W-1:0]      w_row_nxt [RS_ENTRIES];
    logic [OCC_W-1:0]      w_occ_nxt;

    logic [DISP_WIDTH-1:0]       w_disp_ready;
    logic [DISP_WIDTH*IDX_W-1:0] w_disp_entry;
    logic                        w_full;
    logic [DISP_WIDTH-1:0]       w_disp_fire;

    lane_idx_t             w_grant_lane  [ISSUE_WIDTH];
    lane_idx_t             w_retire_lane [RETIRE_WIDTH];
    logic [RS_ENTRIES-1:0] w_grant_hit;
    logic [RS_ENTRIES-1:0] w_retire_hit;
    logic [RS_ENTRIES-1:0] w_replay_hit;

    rs_free_finder #(
        .RS_ENTRIES (RS_ENTRIES),
        .DISP_WIDTH (DISP_WIDTH),
        .IDX_W      (IDX_W)
    ) u_free_finder (
        .i_valid      (r_valid),
        .o_disp_entry (w_disp_entry),
        .o_disp_ready (w_disp_ready),
        .o_full       (w_full)
    );

    assign w_disp_fire = i_disp_valid & w_disp_ready;

    always_comb begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            w_grant_lane[p].vld = i_grant_valid[p];
            w_grant_lane[p].idx = LANE_IDX_W'(i_grant_entry[p*IDX_W +: IDX_W]);
        end
        for (int p = 0; p < RETIRE_WIDTH; p++) begin
            w_retire_lane[p].vld = i_retire_valid[p];
            w_retire_lane[p].idx = LANE_IDX_W'(i_retire_entry[p*IDX_W +: IDX_W]);
        end
    end

`ifdef WAKEUP_REPLAY_EN
    lane_idx_t w_replay_lane [ISSUE_WIDTH];

    always_comb begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            w_replay_lane[p].vld = i_replay_valid[p];
            w_replay_lane[p].idx = LANE_IDX_W'(i_replay_entry[p*IDX_W +: IDX_W]);
        end
    end

    always_comb begin
        w_replay_hit = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                if (w_replay_lane[p].vld && w_replay_lane[p].idx == LANE_IDX_W'(i)) begin
                    w_replay_hit[i] = 1'b1;
                end
            end
        end
        w_replay_hit = w_replay_hit & r_valid;
    end
`else
    assign w_replay_hit = '0;
`endif

    // Duplicate indices collapse into one bit, so each entry is counted once.
    always_comb begin
        w_grant_hit  = '0;
        w_retire_hit = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                if (w_grant_lane[p].vld && w_grant_lane[p].idx == LANE_IDX_W'(i)) begin
                    w_grant_hit[i] = 1'b1;
                end
            end
            for (int p = 0; p < RETIRE_WIDTH; p++) begin
                if (w_retire_lane[p].vld && w_retire_lane[p].idx == LANE_IDX_W'(i)) begin
                    w_retire_hit[i] = 1'b1;
                end
            end
        end
        w_grant_hit  = w_grant_hit & r_valid;
        w_retire_hit = w_retire_hit & r_valid;
    end

    // Priority, lowest to highest: wakeup, grant, replay, dispatch, retire, flush.
    always_comb begin
        w_valid_nxt   = r_valid;
        w_granted_nxt = (r_granted | w_grant_hit) & ~w_replay_hit;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_row_nxt[i] = r_row[i] & ~i_ready_mask;
        end
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (w_disp_fire[k]) begin
                w_row_nxt[w_disp_entry[k*IDX_W +: IDX_W]]     = i_disp_dep_mask[k*DEP_W +: DEP_W] & ~i_ready_mask;
                w_valid_nxt[w_disp_entry[k*IDX_W +: IDX_W]]   = 1'b1;
                w_granted_nxt[w_disp_entry[k*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        w_valid_nxt   = w_valid_nxt & ~w_retire_hit;
        w_granted_nxt = w_granted_nxt & ~w_retire_hit;
        w_occ_nxt     = r_occupancy + OCC_W'(popcount(POP_W'(w_disp_fire)))
                                    - OCC_W'(popcount(POP_W'(w_retire_hit)));
        if (i_flush) begin
            w_valid_nxt   = '0;
            w_granted_nxt = '0;
            w_occ_nxt     = '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                w_row_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_granted   <= '0;
            r_occupancy <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            r_valid     <= w_valid_nxt;
            r_granted   <= w_granted_nxt;
            r_occupancy <= w_occ_nxt;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_row[i] <= w_row_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            o_reqs[i] = r_valid[i] & ~r_granted[i] & ~(|r_row[i]);
        end
    end

    assign o_disp_ready = w_disp_ready;
    assign o_disp_entry = w_disp_entry;
    assign o_full       = w_full;
    assign o_occupancy  = r_occupancy;

    a_occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
        r_occupancy == OCC_W'(popcount(POP_W'(r_valid))));

endmodule

// File: tb/tb_wakeup_mw.sv
// Directed bench for wakeup_mw at RS_ENTRIES=8, NUM_FUS=2, all widths 2.
// Replay checks are compiled in when WAKEUP_REPLAY_EN is defined.
module tb_wakeup_mw;

    localparam int N     = 8;
    localparam int F     = 2;
    localparam int DW    = 2;
    localparam int IW    = 2;
    localparam int RW    = 2;
    localparam int IDX_W = 3;
    localparam int DEP_W = N * F;
    localparam int OCC_W = IDX_W + 1;

    logic                  clk;
    logic                  rst;
    logic [DW-1:0]         disp_valid;
    logic [DW*DEP_W-1:0]   disp_dep_mask;
    logic [DW-1:0]         disp_ready;
    logic [DW*IDX_W-1:0]   disp_entry;
    logic                  full;
    logic [OCC_W-1:0]      occupancy;
    logic [N-1:0]          reqs;
    logic [IW-1:0]         grant_valid;
    logic [IW*IDX_W-1:0]   grant_entry;
    logic [DEP_W-1:0]      ready_mask;
    logic [RW-1:0]         retire_valid;
    logic [RW*IDX_W-1:0]   retire_entry;
    logic                  flush;
`ifdef WAKEUP_REPLAY_EN
    logic [IW-1:0]         replay_valid;
    logic [IW*IDX_W-1:0]   replay_entry;
`endif

    int n_vec;
    int n_miscmp;

    wakeup_mw #(
        .RS_ENTRIES   (N),
        .NUM_FUS      (F),
        .DISP_WIDTH   (DW),
        .ISSUE_WIDTH  (IW),
        .RETIRE_WIDTH (RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_disp_valid    (disp_valid),
        .i_disp_dep_mask (disp_dep_mask),
        .o_disp_ready    (disp_ready),
        .o_disp_entry    (disp_entry),
        .o_full          (full),
        .o_occupancy     (occupancy),
        .o_reqs          (reqs),
        .i_grant_valid   (grant_valid),
        .i_grant_entry   (grant_entry),
        .i_ready_mask    (ready_mask),
        .i_retire_valid  (retire_valid),
        .i_retire_entry  (retire_entry),
`ifdef WAKEUP_REPLAY_EN
        .i_replay_valid  (replay_valid),
        .i_replay_entry  (replay_entry),
`endif
        .i_flush         (flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle();
        disp_valid    = '0;
        disp_dep_mask = '0;
        grant_valid   = '0;
        grant_entry   = '0;
        ready_mask    = '0;
        retire_valid  = '0;
        retire_entry  = '0;
        flush         = 1'b0;
`ifdef WAKEUP_REPLAY_EN
        replay_valid  = '0;
        replay_entry  = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drive_disp(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
        disp_valid    = v;
        disp_dep_mask = {d1, d0};
    endtask

    task automatic drive_grant(input logic [1:0] v, input logic [2:0] e0, input logic [2:0] e1);
        grant_valid = v;
        grant_entry = {e1, e0};
    endtask

    task automatic drive_retire(input logic [1:0] v, input logic [2:0] e0, input logic [2:0] e1);
        retire_valid = v;
        retire_entry = {e1, e0};
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_reqs_hi;

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        rst      = 1'b1;
        idle();
        #2;
        check("rst_reqs",  32'(reqs), 32'h0);
        check("rst_full",  32'(full), 32'h0);
        check("rst_occ",   32'(occupancy), 32'h0);
        check("rst_ready", 32'(disp_ready), 32'h3);
        check("rst_entry", 32'(disp_entry), 32'h08);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // two-lane dispatch, no dependencies
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        check("disp2_reqs",  32'(reqs), 32'h03);
        check("disp2_occ",   32'(occupancy), 32'h2);
        check("disp2_entry", 32'(disp_entry), 32'h1A);

        // fill to seven entries
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        drive_disp(2'b01, 16'h0, 16'h0);
        tick();
        check("fill7_occ",    32'(occupancy), 32'h7);
        check("fill7_ready",  32'(disp_ready), 32'h1);
        check("fill7_entry0", 32'(disp_entry[2:0]), 32'h7);
        check("fill7_reqs",   32'(reqs), 32'h7F);

        // only lane 0 has room
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        check("full_full",  32'(full), 32'h1);
        check("full_occ",   32'(occupancy), 32'h8);
        check("full_reqs",  32'(reqs), 32'hFF);
        check("full_ready", 32'(disp_ready), 32'h0);

        // duplicate grant
        drive_grant(2'b11, 3'd4, 3'd4);
        tick();
        check("grant4_reqs", 32'(reqs), 32'hEF);
        check("grant4_occ",  32'(occupancy), 32'h8);

        // grant and double retire of entry 3 in one cycle
        drive_grant(2'b11, 3'd3, 3'd3);
        drive_retire(2'b11, 3'd3, 3'd3);
        tick();
        check("ret3_occ",    32'(occupancy), 32'h7);
        check("ret3_reqs",   32'(reqs), 32'hE7);
        check("ret3_full",   32'(full), 32'h0);
        check("ret3_entry0", 32'(disp_entry[2:0]), 32'h3);

        // retire of an invalid entry
        drive_retire(2'b01, 3'd3, 3'd0);
        tick();
        check("ret_inv_occ", 32'(occupancy), 32'h7);

        // free entry 2, wakeup in the dispatch cycle
        drive_retire(2'b10, 3'd0, 3'd2);
        tick();
        check("ret2_occ",   32'(occupancy), 32'h6);
        check("ret2_entry", 32'(disp_entry), 32'h1A);
        drive_disp(2'b01, 16'h0020, 16'h0);
        ready_mask = 16'h0020;
        tick();
        check("wake_same_reqs", 32'(reqs), 32'hE7);
        check("wake_same_occ",  32'(occupancy), 32'h7);

        // wakeup one cycle after dispatch
        drive_retire(2'b01, 3'd2, 3'd0);
        tick();
        drive_disp(2'b01, 16'h0020, 16'h0);
        tick();
        check("wake_late_wait", 32'(reqs), 32'hE3);
        ready_mask = 16'h0020;
        tick();
        check("wake_late_reqs", 32'(reqs), 32'hE7);

        // lane hole: lane 0 off, lane 1 on
        drive_retire(2'b11, 3'd5, 3'd6);
        tick();
        check("hole_pre_occ",   32'(occupancy), 32'h5);
        check("hole_pre_entry", 32'(disp_entry), 32'h2B);
        drive_disp(2'b10, 16'h0, 16'h0);
        tick();
        check("hole_reqs", 32'(reqs), 32'hA7);
        check("hole_occ",  32'(occupancy), 32'h6);
        drive_retire(2'b01, 3'd5, 3'd0);
        tick();
        check("hole_ret_occ", 32'(occupancy), 32'h5);

        // flush beats a same-cycle dispatch
        flush = 1'b1;
        drive_disp(2'b01, 16'h0, 16'h0);
        tick();
        check("flush_occ",   32'(occupancy), 32'h0);
        check("flush_reqs",  32'(reqs), 32'h0);
        check("flush_full",  32'(full), 32'h0);
        check("flush_entry", 32'(disp_entry), 32'h08);

        // rebuild entries 0..4, then grant entry 4
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        drive_disp(2'b01, 16'h0, 16'h0);
        tick();
        check("rebuild_reqs", 32'(reqs), 32'h1F);
        drive_grant(2'b01, 3'd4, 3'd0);
        tick();
        check("grant4b_reqs", 32'(reqs), 32'h0F);
        exp_reqs_hi = 8'h6F;
`ifdef WAKEUP_REPLAY_EN
        replay_valid = 2'b01;
        replay_entry = {3'd0, 3'd4};
        tick();
        check("replay4_reqs", 32'(reqs), 32'h1F);
        drive_grant(2'b01, 3'd4, 3'd0);
        replay_valid = 2'b10;
        replay_entry = {3'd4, 3'd0};
        tick();
        check("replay_over_grant", 32'(reqs), 32'h1F);
        exp_reqs_hi = 8'h7F;
`endif

        // grant to an invalid entry is dropped
        drive_grant(2'b10, 3'd0, 3'd6);
        tick();
        drive_disp(2'b11, 16'h0, 16'h0);
        tick();
        check("grant_inv_reqs", 32'(reqs), 32'(exp_reqs_hi));
        check("grant_inv_occ",  32'(occupancy), 32'h7);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_occ",   32'(occupancy), 32'h0);
        check("arst_reqs",  32'(reqs), 32'h0);
        check("arst_full",  32'(full), 32'h0);
        check("arst_ready", 32'(disp_ready), 32'h3);
        check("arst_entry", 32'(disp_entry), 32'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
